// File: rtl/capacitive_sensor_array.sv
// Multi-channel RC-charge capacitive touch scanner.
// Pads are measured round-robin, one channel per measurement: each pad is
// discharged for DISCHARGE_CYCLES, then released and timed until its
// synchronised input reads high (or MAX_COUNT is reached).
// Optional build macro CAP_BASELINE_TRACK_EN: per-channel self-calibrating
// baseline; touch is then judged relative to the tracked baseline rather
// than against the absolute THRESHOLD.
module capacitive_sensor_array #(
  parameter int NUM_CH           = 4,
  parameter int COUNT_W          = 16,
  parameter int DISCHARGE_CYCLES = 64,
  parameter int MAX_COUNT        = 4095,
  parameter int THRESHOLD        = 200,
  parameter int CH_W             = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_CH-1:0]  sensor_in,
  output logic [NUM_CH-1:0]  sensor_drive,
  output logic [COUNT_W-1:0] count_out,
  output logic [CH_W-1:0]    chan_out,
  output logic               result_valid,
  output logic               timeout,
  output logic [NUM_CH-1:0]  touched,
  output logic               busy
);

  localparam int DIS_W = (DISCHARGE_CYCLES < 2) ? 1 : $clog2(DISCHARGE_CYCLES);
  localparam logic [DIS_W-1:0]   DIS_LAST = DIS_W'(DISCHARGE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W:0]   THR_X    = (COUNT_W + 1)'(THRESHOLD);
  localparam logic [CH_W-1:0]    CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISCHARGE,
    S_CHARGE,
    S_REPORT
  } state_t;

  state_t state, state_nxt;

  logic [NUM_CH-1:0]  sync_p0, sync_p1;
  logic [CH_W-1:0]    ch;
  logic [DIS_W-1:0]   dis_cnt;
  logic [COUNT_W-1:0] chg_cnt;
  logic               sense_hi;
  logic               meas_done;

`ifdef CAP_BASELINE_TRACK_EN
  logic [COUNT_W-1:0] baseline [NUM_CH];
  logic [NUM_CH-1:0]  calibrated;

  // Touch when count exceeds baseline+THRESHOLD; one extra bit so the sum never wraps.
  function automatic logic over_base(input logic [COUNT_W-1:0] c,
                                     input logic [COUNT_W-1:0] b);
    return {1'b0, c} > ({1'b0, b} + THR_X);
  endfunction

  // Move the baseline one count toward the latest measurement.
  function automatic logic [COUNT_W-1:0] step_toward(input logic [COUNT_W-1:0] b,
                                                     input logic [COUNT_W-1:0] c);
    if (c > b)      return b + 1'b1;
    else if (c < b) return b - 1'b1;
    else            return b;
  endfunction
`else
  // Absolute touch rule.
  function automatic logic over_abs(input logic [COUNT_W-1:0] c);
    return {1'b0, c} > THR_X;
  endfunction
`endif

  // Select the synchronised sense bit of the active channel.
  always_comb begin
    sense_hi = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) sense_hi = sync_p1[i];
    end
  end

  // Measurement ends on a sensed edge or when the counter reaches its limit.
  assign meas_done = (state == S_CHARGE) && (sense_hi || (chg_cnt == MAX_C));

  // Only the active pad is ever released; every other pad stays discharged.
  always_comb begin
    sensor_drive = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sensor_drive[i] = (state == S_CHARGE) && (ch == CH_W'(i));
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and busy flag.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:      if (start) state_nxt = S_DISCHARGE;
      S_DISCHARGE: if (dis_cnt == DIS_LAST) state_nxt = S_CHARGE;
      S_CHARGE:    if (meas_done) state_nxt = S_REPORT;
      S_REPORT:    state_nxt = start ? S_DISCHARGE : S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Discharge and charge timers; both restart whenever their state is left.
  always_ff @(posedge clock) begin
    if (state != S_DISCHARGE) dis_cnt <= '0;
    else                      dis_cnt <= dis_cnt + 1'b1;

    if (state != S_CHARGE)                  chg_cnt <= '0;
    else if (!sense_hi && chg_cnt != MAX_C) chg_cnt <= chg_cnt + 1'b1;
  end

  // Input synchroniser, channel rotation, result registers and touch state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0      <= '0;
      sync_p1      <= '0;
      ch           <= '0;
      count_out    <= '0;
      chan_out     <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      touched      <= '0;
`ifdef CAP_BASELINE_TRACK_EN
      calibrated   <= '0;
      for (int i = 0; i < NUM_CH; i++) baseline[i] <= '0;
`endif
    end else begin
      sync_p0      <= sensor_in;
      sync_p1      <= sync_p0;
      result_valid <= 1'b0;

      if (meas_done) begin
        count_out    <= chg_cnt;
        chan_out     <= ch;
        timeout      <= !sense_hi;
        result_valid <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch == CH_W'(i)) begin
`ifdef CAP_BASELINE_TRACK_EN
            if (!calibrated[i]) begin
              baseline[i]   <= chg_cnt;
              calibrated[i] <= 1'b1;
              touched[i]    <= 1'b0;
            end else begin
              touched[i] <= over_base(chg_cnt, baseline[i]);
              if (!over_base(chg_cnt, baseline[i]) && sense_hi)
                baseline[i] <= step_toward(baseline[i], chg_cnt);
            end
`else
            touched[i] <= over_abs(chg_cnt);
`endif
          end
        end
      end

      if (state == S_REPORT) ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
    end
  end

endmodule

// File: tb/tb_capacitive_sensor_array.sv
// Directed bench for capacitive_sensor_array with a simple RC pad model:
// a pad reads high once it has been released for more than dly[ch] cycles.
module tb_capacitive_sensor_array;

  localparam int NUM_CH = 4;
  localparam int COUNT_W = 16;
  localparam int CH_W = 2;
  localparam int NEVER = 100000;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [NUM_CH-1:0]  sensor_in;
  logic [NUM_CH-1:0]  sensor_drive;
  logic [COUNT_W-1:0] count_out;
  logic [CH_W-1:0]    chan_out;
  logic               result_valid;
  logic               timeout;
  logic [NUM_CH-1:0]  touched;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;
  int dly[NUM_CH] = '{default: 0};
  int hi_cnt[NUM_CH] = '{default: 0};

  capacitive_sensor_array #(
    .NUM_CH(4), .COUNT_W(16), .DISCHARGE_CYCLES(8),
    .MAX_COUNT(255), .THRESHOLD(20), .CH_W(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .sensor_in(sensor_in),
    .sensor_drive(sensor_drive), .count_out(count_out), .chan_out(chan_out),
    .result_valid(result_valid), .timeout(timeout), .touched(touched), .busy(busy)
  );

  always #5 clock = ~clock;

  // Pad model, updated away from the active edge.
  always @(negedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (sensor_drive[i]) hi_cnt[i] = hi_cnt[i] + 1;
      else                 hi_cnt[i] = 0;
      sensor_in[i] = (hi_cnt[i] > dly[i]);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_report(input int exp_ch);
    bit ok = 0;
    bit stray = 0;
    logic [NUM_CH-1:0] mask;
    mask = ~(NUM_CH'(1) << exp_ch);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      if ((sensor_drive & mask) != 0) stray = 1;
      if (result_valid) begin
        ok = 1;
        break;
      end
    end
    check("report_seen", 32'(ok), 1);
    check("drive_onehot", 32'(stray), 0);
  endtask

  task automatic wait_drive(input int c);
    bit ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (sensor_drive[c]) begin
        ok = 1;
        break;
      end
    end
    check("charge_seen", 32'(ok), 1);
  endtask

  typedef struct {
    int         delay;
    int         chan;
    int         count;
    bit         tmo;
    logic [3:0] tch;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   dc;
    int   bl_delay[5];
    bit   bl_tch[5];

    tbl[0] = '{10,    0, 12,  1'b0, 4'b0000};
    tbl[1] = '{50,    1, 52,  1'b0, 4'b0010};
    tbl[2] = '{NEVER, 2, 255, 1'b1, 4'b0110};
    tbl[3] = '{0,     3, 2,   1'b0, 4'b0110};
    tbl[4] = '{30,    0, 32,  1'b0, 4'b0111};
    tbl[5] = '{18,    1, 20,  1'b0, 4'b0101};
    tbl[6] = '{18,    2, 20,  1'b0, 4'b0001};
    tbl[7] = '{19,    3, 21,  1'b0, 4'b1001};
    bl_delay = '{28, 28, 53, 29, 49};
    bl_tch   = '{0, 0, 1, 0, 0};

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_drive", 32'(sensor_drive), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_count", 32'(count_out), 0);
    check("rst_chan", 32'(chan_out), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_touched", 32'(touched), 0);
    reset = 1'b0;
    @(negedge clock);

`ifndef CAP_BASELINE_TRACK_EN
    // Discharge length before the first charge
    dly[0] = tbl[0].delay;
    start = 1'b1;
    dc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (sensor_drive != 0) break;
      if (busy) dc++;
    end
    check("discharge_cycles", 32'(dc), 8);

    // Table-driven scan with wrap-around and threshold boundaries
    for (int e = 0; e < 8; e++) begin
      dly[tbl[e].chan] = tbl[e].delay;
      wait_report(tbl[e].chan);
      check($sformatf("v%0d_chan", e), 32'(chan_out), 32'(tbl[e].chan));
      check($sformatf("v%0d_count", e), 32'(count_out), 32'(tbl[e].count));
      check($sformatf("v%0d_timeout", e), 32'(timeout), 32'(tbl[e].tmo));
      check($sformatf("v%0d_touched", e), 32'(touched), 32'(tbl[e].tch));
      @(negedge clock);
      check($sformatf("v%0d_valid_pulse", e), 32'(result_valid), 0);
    end

    // Drop start during ch1 charge, then resume at ch2
    for (int i = 0; i < NUM_CH; i++) dly[i] = 5;
    wait_report(0);
    check("resume_ch0_count", 32'(count_out), 7);
    wait_drive(1);
    start = 1'b0;
    wait_report(1);
    check("stop_chan", 32'(chan_out), 1);
    @(negedge clock);
    check("stop_busy", 32'(busy), 0);
    check("stop_drive", 32'(sensor_drive), 0);
    repeat (5) @(negedge clock);
    check("idle_hold_busy", 32'(busy), 0);
    start = 1'b1;
    wait_report(2);
    check("restart_chan", 32'(chan_out), 2);

    // Asynchronous reset in the middle of a charge
    wait_drive(3);
    #2 reset = 1'b1;
    #1;
    check("arst_drive", 32'(sensor_drive), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_count", 32'(count_out), 0);
    check("arst_chan", 32'(chan_out), 0);
    check("arst_touched", 32'(touched), 0);
    check("arst_timeout", 32'(timeout), 0);
    @(negedge clock);
    reset = 1'b0;
    wait_report(0);
    check("post_rst_chan", 32'(chan_out), 0);
    check("post_rst_count", 32'(count_out), 7);
`else
    // Baseline tracking on ch0: counts 30,30,55,31,51
    for (int i = 0; i < NUM_CH; i++) dly[i] = 0;
    dly[0] = bl_delay[0];
    start = 1'b1;
    for (int r = 0; r < 5; r++) begin
      dly[0] = bl_delay[r];
      for (int c = 0; c < NUM_CH; c++) begin
        wait_report(c);
        check($sformatf("bl%0d_chan", r), 32'(chan_out), 32'(c));
        if (c == 0) begin
          check($sformatf("bl%0d_count", r), 32'(count_out), 32'(bl_delay[r] + 2));
          check($sformatf("bl%0d_touched0", r), 32'(touched[0]), 32'(bl_tch[r]));
        end
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/capacitive_sensor_array.md
Name: capacitive_sensor_array

Overview:
Parametrised multi-channel successor to the single-pad capacitive sensor. It scans NUM_CH RC-charge touch pads round-robin, one channel per measurement. Each measurement discharges the pad, then releases it to charge and counts cycles until the pad input reads high. It reports a per-channel charge count plus a touched bitmask, which the whack-a-mole game logic and the LCD status path consume.

Parameters:
NUM_CH, 4, number of pad channels (1..16)
COUNT_W, 16, width of charge counter and count_out
DISCHARGE_CYCLES, 64, cycles each pad is actively driven low before charging (>=1)
MAX_COUNT, 4095, timeout count; must fit in COUNT_W
THRESHOLD, 200, touch threshold in counts
CH_W, 2, width of channel index; must equal max(1, clog2(NUM_CH))

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
start  in  1  level; while high, channels are scanned continuously
sensor_in  in  NUM_CH  raw pad sense inputs (asynchronous)
sensor_drive  out  NUM_CH  per-pad drive: 0 = discharge (drive low), 1 = release/charge
count_out  out  COUNT_W  charge count of the last completed measurement
chan_out  out  CH_W  channel index of count_out
result_valid  out  1  one-cycle pulse when count_out/chan_out are updated
timeout  out  1  high with result_valid when the measurement hit MAX_COUNT
touched  out  NUM_CH  registered per-channel touch state
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time including mid-measurement): state=IDLE, channel index=0, all outputs 0, sensor_drive all 0 (all pads discharged). Synchroniser flops are cleared.
- Each sensor_in bit passes through a 2-flop synchroniser. All comparisons use the synchronised value.
- Non-selected channels always have sensor_drive=0.
- IDLE: when start=1, go to DISCHARGE on the next edge. Otherwise stay in IDLE.
- DISCHARGE: sensor_drive[ch]=0 for exactly DISCHARGE_CYCLES cycles. Then go to CHARGE with counter=0.
- CHARGE: sensor_drive[ch]=1. Cycle 0 is the first CHARGE cycle, with count=0. Each cycle, evaluate in this order:
  - if sync_in[ch]=1: capture count and go to REPORT;
  - else if count==MAX_COUNT: capture MAX_COUNT, set the timeout flag, go to REPORT;
  - else count++.
- Latency: if raw sensor_in[ch] rises in CHARGE cycle K, the reported count is K+2. If sync_in is already high at cycle 0, the reported count is 0.
- REPORT (1 cycle): sensor_drive[ch]=0. count_out, chan_out and timeout are registered and result_valid=1 for exactly this cycle. touched[ch] updates (rule below); other touched bits hold.
- After REPORT: ch = (ch==NUM_CH-1) ? 0 : ch+1. If start=1, go to DISCHARGE; else go to IDLE.
- start falling mid-measurement: the current channel completes through REPORT, then the block returns to IDLE. The channel index is retained, so the next start resumes at the next channel.
- Touch rule, base build: touched[ch] = (count > THRESHOLD). A timeout counts as touched when MAX_COUNT > THRESHOLD.
- count_out, chan_out, timeout and touched hold their values between reports.

Optional Feature:
Macro CAP_BASELINE_TRACK_EN.
- Defined: per-channel COUNT_W baseline registers and a per-channel "calibrated" bit, both cleared on reset.
- The first REPORT for a channel after reset loads baseline=count and sets calibrated; touched stays 0 for that report.
- Later reports use touched = (count > baseline + THRESHOLD), computed at COUNT_W+1 bits so it never wraps.
- When not touched and not timeout, baseline moves 1 toward count (+1 if count>baseline, -1 if count<baseline, unchanged if equal).
- Undefined: no baseline storage; the absolute THRESHOLD rule applies.

Test Plan:
1. NUM_CH=4, DISCHARGE_CYCLES=8, MAX_COUNT=255, THRESHOLD=20. start=1; pad model raises ch0 input 10 cycles after drive rises -> result_valid with chan_out=0, count_out=12, timeout=0, touched[0]=0. Exactly 8 discharge cycles precede it.
2. Same setup, ch1 input delayed 50 cycles -> count_out=52, touched[1]=1. Channel order 0,1,2,3,0 observed with wrap-around.
3. ch2 input never rises -> count_out=255, timeout=1 for one cycle, touched[2]=1 (255>20). The scan continues to ch3.
4. Drop start during ch1 CHARGE -> ch1 REPORT occurs, then busy=0 and sensor_drive=0. Re-raise start -> the next measurement is ch2.
5. Assert reset mid-CHARGE -> all outputs and sensor_drive go to 0 immediately, without waiting for a clock edge. After release with start=1, the scan begins at ch0.
6. With CAP_BASELINE_TRACK_EN defined, ch0 counts 30,30,55,31 -> touched[0] = 0,0,1,0. Baseline stays 30 through the touched report, then becomes 31.
